// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared sizes, sample type and sequencer states for the conv input path
package conv_pkg;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 19;
  localparam int ADDR_W = 5;
  localparam int K      = 3;

  typedef logic [DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } iwr_state_e;
endpackage

// File: rtl/conv_window_shreg.sv
// rtl/conv_window_shreg.sv - K-slot sample shift register with fill counter and synchronous clear
module conv_window_shreg #(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int K      = conv_pkg::K,
  parameter int FW     = $clog2(K + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                shift,
  input  logic [DATA_W-1:0]   din,
  output logic [K*DATA_W-1:0] win,
  output logic [FW-1:0]       fill
);
  logic [DATA_W-1:0] slot [K];

  // Slot 0 holds the oldest sample; new samples always enter at slot K-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) slot[i] <= '0;
      fill <= '0;
    end else if (clr) begin
      for (int i = 0; i < K; i++) slot[i] <= '0;
      fill <= '0;
    end else if (shift) begin
      for (int i = 0; i < K - 1; i++) slot[i] <= slot[i+1];
      slot[K-1] <= din;
      if (fill != FW'(K)) fill <= fill + 1'b1;
    end
  end

  always_comb begin
    win = '0;
    for (int i = 0; i < K; i++) win[i*DATA_W +: DATA_W] = slot[i];
  end
endmodule

// File: rtl/conv_input_window_reader.sv
// rtl/conv_input_window_reader.sv - input RAM read sequencer streaming sliding K-sample windows
// Optional "same" zero padding enabled by CONV_IWR_ZERO_PAD_EN.
module conv_input_window_reader #(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int DEPTH  = conv_pkg::DEPTH,
  parameter int ADDR_W = conv_pkg::ADDR_W,
  parameter int K      = conv_pkg::K
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_en,
  input  logic [DATA_W-1:0]   rd_data,
  output logic [K*DATA_W-1:0] win_data,
  output logic [ADDR_W-1:0]   win_idx,
  output logic                win_valid,
  input  logic                win_ready,
  output logic                busy,
  output logic                done
);
  import conv_pkg::*;

`ifdef CONV_IWR_ZERO_PAD_EN
  localparam int P    = (K - 1) / 2;
  localparam int NWIN = DEPTH;
`else
  localparam int P    = 0;
  localparam int NWIN = DEPTH - K + 1;
`endif
  localparam int FW = $clog2(K + 1);
  localparam logic [1:0]      S_IDLE   = 2'(IDLE);
  localparam logic [1:0]      S_FILL   = 2'(FILL);
  localparam logic [1:0]      S_STREAM = 2'(STREAM);
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state;
  logic [ADDR_W:0]   next_addr;
  logic [ADDR_W:0]   lead_cnt;
  logic              hold;
  logic [FW-1:0]     fill;
  logic              go, full, xfer, last_xfer;
  logic              pad_lead, pad_trail, src_avail, shift, consume;
  logic [DATA_W-1:0] shift_din;

  assign busy      = (state != S_IDLE);
  assign go        = (state == S_IDLE) && start && !done;
  assign full      = (fill == FW'(K));
  assign win_valid = (state == S_STREAM) && full;
  assign xfer      = win_valid && win_ready;
  assign last_xfer = xfer && (win_idx == ADDR_W'(NWIN - 1));

  // Pad samples are always "available", exactly like a held RAM sample.
  assign pad_lead = (lead_cnt != '0);
`ifdef CONV_IWR_ZERO_PAD_EN
  assign pad_trail = busy && (next_addr == DEPTH_C) && !hold;
`else
  assign pad_trail = 1'b0;
`endif
  assign src_avail = pad_lead || hold || pad_trail;
  assign shift     = busy && src_avail && (!full || xfer) && !last_xfer;
  assign consume   = shift && hold && !pad_lead;
  assign shift_din = consume ? rd_data : '0;

  assign rd_en   = busy && (next_addr < DEPTH_C) && (!hold || consume);
  assign rd_addr = next_addr[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      next_addr <= '0;
      lead_cnt  <= '0;
      hold      <= 1'b0;
      win_idx   <= '0;
      done      <= 1'b0;
    end else begin
      done <= last_xfer;
      if (state == S_IDLE) begin
        if (go) begin
          state     <= S_FILL;
          next_addr <= '0;
          lead_cnt  <= (ADDR_W+1)'(P);
          hold      <= 1'b0;
          win_idx   <= '0;
        end
      end else begin
        if (rd_en) next_addr <= next_addr + 1'b1;
        if (rd_en) hold <= 1'b1;
        else if (consume) hold <= 1'b0;
        if (shift && pad_lead) lead_cnt <= lead_cnt - 1'b1;
        if (xfer) win_idx <= win_idx + 1'b1;
        if (state == S_FILL && shift && fill == FW'(K - 1)) state <= S_STREAM;
        if (last_xfer) begin
          state     <= S_IDLE;
          next_addr <= '0;
          hold      <= 1'b0;
        end
      end
    end
  end

  conv_window_shreg #(.DATA_W(DATA_W), .K(K), .FW(FW)) u_shreg (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go),
    .shift (shift),
    .din   (shift_din),
    .win   (win_data),
    .fill  (fill)
  );
endmodule

// File: tb/tb_conv_input_window_reader.sv
// tb/tb_conv_input_window_reader.sv - directed bench: full rate, backpressure, reset, start-while-busy, K==DEPTH
module tb_conv_input_window_reader;
  localparam int DW = 16;
  localparam int AW = 5;
  localparam int DEPTH = 19;
  localparam int K1 = 3;
  localparam int K2 = 19;
`ifdef CONV_IWR_ZERO_PAD_EN
  localparam int P1 = 1;
  localparam int P2 = 9;
  localparam int NW1 = 19;
  localparam int NW2 = 19;
`else
  localparam int P1 = 0;
  localparam int P2 = 0;
  localparam int NW1 = 17;
  localparam int NW2 = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, win_ready = 1'b1;
  logic [AW-1:0] rd_addr, win_idx;
  logic rd_en, win_valid, busy, done;
  logic [DW-1:0] rd_data = '0;
  logic [K1*DW-1:0] win_data;

  logic start2 = 1'b0, ready2 = 1'b1;
  logic [AW-1:0] rd_addr2, win_idx2;
  logic rd_en2, win_valid2, busy2, done2;
  logic [DW-1:0] rd_data2 = '0;
  logic [K2*DW-1:0] win_data2;

  conv_input_window_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data), .win_data(win_data), .win_idx(win_idx), .win_valid(win_valid),
    .win_ready(win_ready), .busy(busy), .done(done)
  );

  conv_input_window_reader #(.K(K2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .rd_addr(rd_addr2), .rd_en(rd_en2),
    .rd_data(rd_data2), .win_data(win_data2), .win_idx(win_idx2), .win_valid(win_valid2),
    .win_ready(ready2), .busy(busy2), .done(done2)
  );

  // RAM[i] = i+1, one-cycle registered read, data held between reads
  always @(posedge clk) begin
    if (rd_en)  rd_data  <= {11'd0, rd_addr} + 16'd1;
    if (rd_en2) rd_data2 <= {11'd0, rd_addr2} + 16'd1;
  end

  int n_vec = 0;
  int n_fail = 0;

  function automatic logic [DW-1:0] exp_s(input int n, input int p);
    if (n < p || n >= p + DEPTH) return '0;
    return DW'(n - p + 1);
  endfunction

  function automatic logic [K1*DW-1:0] exp_win1(input int w);
    logic [K1*DW-1:0] r;
    for (int i = 0; i < K1; i++) r[i*DW +: DW] = exp_s(w + i, P1);
    return r;
  endfunction

  function automatic logic [K2*DW-1:0] exp_win2(input int w);
    logic [K2*DW-1:0] r;
    for (int i = 0; i < K2; i++) r[i*DW +: DW] = exp_s(w + i, P2);
    return r;
  endfunction

  logic [K1*DW-1:0] got_data[$];
  int got_idx[$];
  int n_rd, n_done, n_stall_bad, n_rd_stall, n_addr_bad;
  int first_rd_e, first_valid_e, last_xfer_e, done_e, busy_after_done, timed_out;
  logic busy_e0;

  // Drives one pass on dut and records what it observed.
  task automatic run_pass(input int mode, input int stop_after, input int poke_at);
    int e, post;
    logic prev_stall, seen_done;
    logic [K1*DW-1:0] prev_data;
    logic [AW-1:0] prev_idx;
    got_data.delete(); got_idx.delete();
    n_rd = 0; n_done = 0; n_stall_bad = 0; n_rd_stall = 0; n_addr_bad = 0;
    first_rd_e = -1; first_valid_e = -1; last_xfer_e = -1; done_e = -1;
    busy_after_done = 0; timed_out = 0; busy_e0 = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    e = 0; post = 0; prev_stall = 1'b0; seen_done = 1'b0;
    prev_data = '0; prev_idx = '0;
    while (1) begin
      win_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      start = (poke_at >= 0) && ((win_valid && int'(win_idx) == poke_at) || done);
      #1;
      if (e == 0) busy_e0 = busy;
      if (rd_en) begin
        n_rd++;
        if (first_rd_e < 0) first_rd_e = e;
        if (int'(rd_addr) >= DEPTH) n_addr_bad++;
        if (win_valid && !win_ready) n_rd_stall++;
      end
      if (win_valid && first_valid_e < 0) first_valid_e = e;
      if (prev_stall && (!win_valid || win_data !== prev_data || win_idx !== prev_idx)) n_stall_bad++;
      prev_stall = win_valid && !win_ready;
      prev_data = win_data; prev_idx = win_idx;
      if (done) begin
        n_done++;
        if (done_e < 0) done_e = e;
        seen_done = 1'b1;
      end
      if (seen_done && busy) busy_after_done++;
      if (win_valid && win_ready) begin
        got_data.push_back(win_data);
        got_idx.push_back(int'(win_idx));
        last_xfer_e = e;
        if (stop_after >= 0 && int'(win_idx) == stop_after) begin
          start = 1'b0;
          return;
        end
      end
      if (seen_done) post++;
      if (post > 3) break;
      if (e >= 400) begin timed_out = 1; break; end
      @(posedge clk); e++; #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (rd_addr !== '0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
    n_vec++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
    n_vec++; if (win_data !== '0) begin n_fail++; $display("FAIL reset_win_data: got %h expected 0", win_data); end
    n_vec++; if (win_idx !== '0) begin n_fail++; $display("FAIL reset_win_idx: got %0d expected 0", win_idx); end
    n_vec++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL reset_win_valid: got %b expected 0", win_valid); end
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_vec++; if ({rd_en2, win_valid2, busy2, done2} !== 4'b0 || win_data2 !== '0) begin
      n_fail++; $display("FAIL reset_dut2: got %b expected 0000", {rd_en2, win_valid2, busy2, done2});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_full_rate;
    run_pass(0, -1, -1);
    n_vec++; if (timed_out != 0) begin n_fail++; $display("FAIL full_timeout: got %0d expected 0", timed_out); end
    n_vec++; if (got_data.size() != NW1) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", got_data.size(), NW1); end
    for (int w = 0; w < got_data.size() && w < NW1; w++) begin
      n_vec++;
      if (got_data[w] !== exp_win1(w) || got_idx[w] != w) begin
        n_fail++; $display("FAIL full_win%0d: got %h/%0d expected %h/%0d", w, got_data[w], got_idx[w], exp_win1(w), w);
      end
    end
    n_vec++; if (n_done != 1) begin n_fail++; $display("FAIL full_done_count: got %0d expected 1", n_done); end
    n_vec++; if (n_rd != DEPTH) begin n_fail++; $display("FAIL full_reads: got %0d expected %0d", n_rd, DEPTH); end
    n_vec++; if (busy_e0 !== 1'b1) begin n_fail++; $display("FAIL full_busy_e0: got %b expected 1", busy_e0); end
    n_vec++; if (first_rd_e != 0) begin n_fail++; $display("FAIL full_first_rd: got %0d expected 0", first_rd_e); end
    n_vec++; if (first_valid_e != K1 + 1 - P1) begin n_fail++; $display("FAIL full_latency: got %0d expected %0d", first_valid_e, K1 + 1 - P1); end
    n_vec++; if (last_xfer_e - first_valid_e != NW1 - 1) begin
      n_fail++; $display("FAIL full_rate: got %0d expected %0d", last_xfer_e - first_valid_e, NW1 - 1);
    end
    n_vec++; if (done_e != last_xfer_e + 1) begin n_fail++; $display("FAIL full_done_time: got %0d expected %0d", done_e, last_xfer_e + 1); end
    n_vec++; if (n_addr_bad != 0) begin n_fail++; $display("FAIL full_addr_range: got %0d expected 0", n_addr_bad); end
  endtask

  task automatic test_backpressure;
    run_pass(1, -1, -1);
    n_vec++; if (got_data.size() != NW1 || timed_out != 0) begin
      n_fail++; $display("FAIL bp_count: got %0d expected %0d", got_data.size(), NW1);
    end
    for (int w = 0; w < got_data.size() && w < NW1; w++) begin
      n_vec++;
      if (got_data[w] !== exp_win1(w) || got_idx[w] != w) begin
        n_fail++; $display("FAIL bp_win%0d: got %h/%0d expected %h/%0d", w, got_data[w], got_idx[w], exp_win1(w), w);
      end
    end
    n_vec++; if (n_stall_bad != 0) begin n_fail++; $display("FAIL bp_stable: got %0d expected 0", n_stall_bad); end
    n_vec++; if (n_rd_stall != 0) begin n_fail++; $display("FAIL bp_read_in_stall: got %0d expected 0", n_rd_stall); end
    n_vec++; if (n_rd != DEPTH) begin n_fail++; $display("FAIL bp_reads: got %0d expected %0d", n_rd, DEPTH); end
    n_vec++; if (n_done != 1) begin n_fail++; $display("FAIL bp_done_count: got %0d expected 1", n_done); end
  endtask

  task automatic test_reset_mid_pass;
    int dseen;
    run_pass(0, 5, -1);
    n_vec++; if (got_data.size() != 6) begin n_fail++; $display("FAIL mid_windows_before: got %0d expected 6", got_data.size()); end
    rst_n = 1'b0;
    #1;
    n_vec++; if ({rd_en, win_valid, busy, done} !== 4'b0) begin
      n_fail++; $display("FAIL mid_reset_ctrl: got %b expected 0000", {rd_en, win_valid, busy, done});
    end
    n_vec++; if (win_data !== '0 || win_idx !== '0 || rd_addr !== '0) begin
      n_fail++; $display("FAIL mid_reset_data: got %h/%0d/%0d expected 0/0/0", win_data, win_idx, rd_addr);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    dseen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || busy) dseen++;
    end
    n_vec++; if (dseen != 0) begin n_fail++; $display("FAIL mid_no_done: got %0d expected 0", dseen); end
    run_pass(0, -1, -1);
    n_vec++; if (got_data.size() != NW1) begin n_fail++; $display("FAIL mid_replay_count: got %0d expected %0d", got_data.size(), NW1); end
    n_vec++; if (got_data.size() < 1 || got_data[0] !== exp_win1(0) || got_idx[0] != 0) begin
      n_fail++; $display("FAIL mid_replay_first: got %h expected %h", (got_data.size() > 0) ? got_data[0] : '0, exp_win1(0));
    end
    n_vec++; if (n_done != 1) begin n_fail++; $display("FAIL mid_replay_done: got %0d expected 1", n_done); end
  endtask

  task automatic test_start_while_busy;
    run_pass(0, -1, 4);
    n_vec++; if (got_data.size() != NW1) begin n_fail++; $display("FAIL swb_count: got %0d expected %0d", got_data.size(), NW1); end
    for (int w = 0; w < got_data.size() && w < NW1; w++) begin
      n_vec++;
      if (got_data[w] !== exp_win1(w) || got_idx[w] != w) begin
        n_fail++; $display("FAIL swb_win%0d: got %h/%0d expected %h/%0d", w, got_data[w], got_idx[w], exp_win1(w), w);
      end
    end
    n_vec++; if (n_done != 1) begin n_fail++; $display("FAIL swb_done_count: got %0d expected 1", n_done); end
    n_vec++; if (busy_after_done != 0) begin n_fail++; $display("FAIL swb_start_at_done: got %0d expected 0", busy_after_done); end
  endtask

  task automatic test_k_equals_depth;
    int nwin, nrd, ndone, first_v, last_e, done_at;
    nwin = 0; nrd = 0; ndone = 0; first_v = -1; last_e = -1; done_at = -1;
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int e = 0; e < 200; e++) begin
      #1;
      if (rd_en2) nrd++;
      if (win_valid2) begin
        if (first_v < 0) first_v = e;
        n_vec++;
        if (win_data2 !== exp_win2(nwin) || int'(win_idx2) != nwin) begin
          n_fail++; $display("FAIL keqd_win%0d: got %h/%0d expected %h/%0d", nwin, win_data2, win_idx2, exp_win2(nwin), nwin);
        end
        nwin++; last_e = e;
      end
      if (done2) begin ndone++; if (done_at < 0) done_at = e; end
      if (done_at >= 0 && e > done_at + 2) break;
      @(posedge clk); #1;
    end
    n_vec++; if (nwin != NW2) begin n_fail++; $display("FAIL keqd_count: got %0d expected %0d", nwin, NW2); end
    n_vec++; if (ndone != 1) begin n_fail++; $display("FAIL keqd_done_count: got %0d expected 1", ndone); end
    n_vec++; if (done_at != last_e + 1) begin n_fail++; $display("FAIL keqd_done_time: got %0d expected %0d", done_at, last_e + 1); end
    n_vec++; if (nrd != DEPTH) begin n_fail++; $display("FAIL keqd_reads: got %0d expected %0d", nrd, DEPTH); end
    n_vec++; if (first_v != K2 + 1 - P2) begin n_fail++; $display("FAIL keqd_latency: got %0d expected %0d", first_v, K2 + 1 - P2); end
  endtask

  initial begin
    test_reset;
    test_full_rate;
    test_backpressure;
    test_reset_mid_pass;
    test_start_while_busy;
    test_k_equals_depth;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
